alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes the low 32 bits of an unsigned 32x32 product by time-sharing the existing single-cycle ALU.
- Uses only the ALU's add, shift-left-by-1 and shift-right-by-1 functions, issuing one ALU operation per cycle.
- Sits beside the ALU in the execute stage and owns the ALU operand and function lines while busy.
- Core control handshakes with it via start, busy and done.

Parameters:
- EARLY_EXIT, 1: when 1, finish as soon as the remaining multiplier is zero. When 0, always process all 32 multiplier bits.
- WIDTH, 32: operand and result width. Only 32 is supported; fixed to the ALU width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  32  multiplicand; sampled with start.
- op_b  in  32  multiplier; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; result valid from this cycle.
- result  out  32  low 32 bits of op_a*op_b; held until the next accepted start.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_function  out  4  ALU function code.
- alu_result  in  32  ALU result (combinational, same cycle).
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - Internal acc, mcand, mplier and bit counter are cleared.
  - Any operation in flight is abandoned. No done is produced.
- Registers: acc, mcand, mplier (32b each); cnt (6b, used when EARLY_EXIT=0).
- States: IDLE, ADD, SHL, SHR, FIN.
- IDLE, start=1:
  - Latch acc=0, mcand=op_a, mplier=op_b, cnt=0.
  - If EARLY_EXIT=1 and op_b==0, go to FIN (result 0).
  - Else if op_b[0]=1, go to ADD.
  - Else go to SHL.
- ADD: alu_a=acc, alu_b=mcand, alu_function=0010. acc<=alu_result. Next state SHL.
- SHL: alu_a=mcand, alu_b=0, alu_function=0101. mcand<=alu_result. Next state SHR.
- SHR: alu_a=mplier, alu_b=0, alu_function=1000. mplier<=alu_result, cnt<=cnt+1.
  - With EARLY_EXIT=1: go to FIN if alu_zero=1.
  - With EARLY_EXIT=0: go to FIN if cnt==31.
  - Otherwise go to ADD if alu_result[0]=1, else SHL.
- FIN: result<=acc, done=1 (registered so it is high exactly this one cycle), busy=0. Next state IDLE.
- ALU drive outside ADD/SHL/SHR: alu_a=0, alu_b=0, alu_function=0000.
- Arithmetic: ALU add wraps modulo 2^32, so the result is exactly the low 32 bits of the product. No overflow flag is provided.
- Latency from the start-accept edge to done high:
  - EARLY_EXIT=1: (bits processed)*2 + popcount(processed bits) + 1 cycles.
  - EARLY_EXIT=0: 64 + popcount(op_b) + 1 cycles.
  - op_b==0 with EARLY_EXIT=1: done is high in the cycle after start is accepted.
- start while not IDLE (busy or FIN): ignored. op_a and op_b are not re-sampled.
- start held high across FIN->IDLE: a new operation is accepted in IDLE on the next edge. Back-to-back operations are legal with one IDLE cycle between them.
- result is unchanged during a new operation until its FIN.

Decomposition:
- alu_pkg holds the ALU function-code constants (AND=0000, ADD=0010, SHL=0101, SHR=1000) and the state encoding.
- These constants are shared with the ALU and the main decoder.
- There is no sub-module; the testbench instantiates alu_mul_seq connected to the existing alu.

Test Plan:
- EARLY_EXIT=1, op_a=3, op_b=5 -> ALU sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR; done 9 cycles after accept; result=15.
- op_a=0x12345678, op_b=0 (EARLY_EXIT=1) -> done in the cycle after accept; result=0; no ALU add issued.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001; done after 97 cycles (EARLY_EXIT=1).
- EARLY_EXIT=0, op_a=7, op_b=2 -> result=14; done exactly 66 cycles after accept.
- Pulse start again while busy with different operands -> ignored; result equals the first product; only one done pulse.
- Deassert rst_n mid-operation (cycle 4 of 3*5) -> busy, done and result go to 0 immediately. After release, a new 6*7 request completes with result=42.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes and the multiply sequencer state encoding.
// Used by the ALU, the main decoder and alu_mul_seq.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_SHR = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHL,
    ST_SHR,
    ST_FIN
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle execute-stage ALU; purely combinational, zero latency.
// No flow control: result and zero follow the operands in the same cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (func)
      ALU_AND: result = a & b;
      ALU_ADD: result = a + b;
      ALU_SHL: result = a << 1;
      ALU_SHR: result = a >> 1;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add 32x32 multiplier (low word) time-sharing the ALU, one op per cycle;
// latency 2 cycles per multiplier bit plus one per set bit plus FIN. start is ignored unless IDLE.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_function,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [5:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done     <= (state_d == ST_FIN);
      // Capture on entry to FIN so result is valid in the same cycle as done;
      // a zero multiplier jumps straight from IDLE while acc is still being cleared.
      if (state_d == ST_FIN)
        result <= (state_q == ST_IDLE) ? '0 : acc_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    alu_a        = '0;
    alu_b        = '0;
    alu_function = ALU_AND;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          if (EARLY_EXIT && (op_b == '0)) state_d = ST_FIN;
          else if (op_b[0])               state_d = ST_ADD;
          else                            state_d = ST_SHL;
        end
      end
      ST_ADD: begin
        alu_a        = acc_q;
        alu_b        = mcand_q;
        alu_function = ALU_ADD;
        acc_d        = alu_result;
        state_d      = ST_SHL;
      end
      ST_SHL: begin
        alu_a        = mcand_q;
        alu_function = ALU_SHL;
        mcand_d      = alu_result;
        state_d      = ST_SHR;
      end
      ST_SHR: begin
        alu_a        = mplier_q;
        alu_function = ALU_SHR;
        mplier_d     = alu_result;
        cnt_d        = cnt_q + 6'd1;
        if (EARLY_EXIT ? alu_zero : (cnt_q == 6'(WIDTH - 1))) state_d = ST_FIN;
        else if (alu_result[0])                                state_d = ST_ADD;
        else                                                   state_d = ST_SHL;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_ADD) || (state_q == ST_SHL) || (state_q == ST_SHR);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: one early-exit and one full-length instance, each wired to an ALU.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_e = 1'b0, start_f = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;

  logic        busy_e, done_e, zero_e;
  logic [31:0] result_e, a_e, b_e, r_e;
  logic [3:0]  func_e;
  logic        busy_f, done_f, zero_f;
  logic [31:0] result_f, a_f, b_f, r_f;
  logic [3:0]  func_f;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  funcs [0:127];

  always #5 clk = ~clk;

  alu_mul_seq #(.EARLY_EXIT(1'b1), .WIDTH(32)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .op_a(op_a), .op_b(op_b),
    .busy(busy_e), .done(done_e), .result(result_e),
    .alu_a(a_e), .alu_b(b_e), .alu_function(func_e),
    .alu_result(r_e), .alu_zero(zero_e)
  );
  alu #(.WIDTH(32)) alu_e (.a(a_e), .b(b_e), .func(func_e), .result(r_e), .zero(zero_e));

  alu_mul_seq #(.EARLY_EXIT(1'b0), .WIDTH(32)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .op_a(op_a), .op_b(op_b),
    .busy(busy_f), .done(done_f), .result(result_f),
    .alu_a(a_f), .alu_b(b_f), .alu_function(func_f),
    .alu_result(r_f), .alu_zero(zero_f)
  );
  alu #(.WIDTH(32)) alu_f (.a(a_f), .b(b_f), .func(func_f), .result(r_f), .zero(zero_f));

  // Drive a one-cycle start; returns at the negedge of cycle 1 after the accept edge.
  task automatic issue(input bit sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    if (sel) start_f = 1'b1; else start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    start_f = 1'b0;
  endtask

  // From cycle 1, logs ALU function per cycle until done; lat=-1 on timeout.
  task automatic wait_done(input bit sel, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      funcs[k] = sel ? func_f : func_e;
      if ((sel ? done_f : done_e) === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy_e !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_e); end
    checks++; if (done_e !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_e); end
    checks++; if (result_e !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_e); end
    checks++; if (func_e !== ALU_AND) begin failures++; $display("FAIL reset_func got=%b exp=0000", func_e); end
    checks++; if (done_f !== 1'b0) begin failures++; $display("FAIL reset_done_f got=%b exp=0", done_f); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0] exp_seq [1:8];
    exp_seq[1] = ALU_ADD; exp_seq[2] = ALU_SHL; exp_seq[3] = ALU_SHR; exp_seq[4] = ALU_SHL;
    exp_seq[5] = ALU_SHR; exp_seq[6] = ALU_ADD; exp_seq[7] = ALU_SHL; exp_seq[8] = ALU_SHR;
    issue(1'b0, 32'd3, 32'd5);
    checks++; if (busy_e !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy_e); end
    wait_done(1'b0, 40, lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (result_e !== 32'd15) begin failures++; $display("FAIL basic_result got=%0d exp=15", result_e); end
    checks++; if (busy_e !== 1'b0) begin failures++; $display("FAIL basic_busy_fin got=%b exp=0", busy_e); end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (funcs[i] !== exp_seq[i]) begin
        failures++; $display("FAIL basic_seq[%0d] got=%b exp=%b", i, funcs[i], exp_seq[i]);
      end
    end
    checks++; if (funcs[9] !== ALU_AND) begin failures++; $display("FAIL basic_fin_func got=%b exp=0000", funcs[9]); end
    @(negedge clk);
    checks++; if (done_e !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done_e); end
  endtask

  task automatic test_zero();
    int lat;
    issue(1'b0, 32'h12345678, 32'd0);
    checks++; if (busy_e !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy_e); end
    wait_done(1'b0, 10, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (result_e !== 32'd0) begin failures++; $display("FAIL zero_result got=%h exp=0", result_e); end
    checks++; if (funcs[1] !== ALU_AND) begin failures++; $display("FAIL zero_no_add got=%b exp=0000", funcs[1]); end
  endtask

  task automatic test_ones();
    int lat;
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, 120, lat);
    checks++; if (lat != 97) begin failures++; $display("FAIL ones_latency got=%0d exp=97", lat); end
    checks++; if (result_e !== 32'h00000001) begin failures++; $display("FAIL ones_result got=%h exp=00000001", result_e); end
  endtask

  task automatic test_full_length();
    int lat;
    issue(1'b1, 32'd7, 32'd2);
    wait_done(1'b1, 120, lat);
    checks++; if (lat != 66) begin failures++; $display("FAIL full_latency got=%0d exp=66", lat); end
    checks++; if (result_f !== 32'd14) begin failures++; $display("FAIL full_result got=%0d exp=14", result_f); end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int done_at = -1;
    issue(1'b0, 32'd4, 32'd3);
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) begin
        checks++; if (result_e !== 32'h00000001) begin failures++; $display("FAIL ignore_result_held got=%h exp=00000001", result_e); end
      end
      if (k == 3) begin
        checks++; if (busy_e !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", busy_e); end
        op_a = 32'd9; op_b = 32'd9; start_e = 1'b1;
      end
      if (k == 4) start_e = 1'b0;
      if (done_e === 1'b1) begin pulses++; if (done_at < 0) done_at = k; end
      @(negedge clk);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    checks++; if (done_at != 7) begin failures++; $display("FAIL ignore_latency got=%0d exp=7", done_at); end
    checks++; if (result_e !== 32'd12) begin failures++; $display("FAIL ignore_result got=%0d exp=12", result_e); end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(1'b0, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy_e !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy_e); end
    checks++; if (done_e !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", done_e); end
    checks++; if (result_e !== 32'd0) begin failures++; $display("FAIL mid_reset_result got=%h exp=0", result_e); end
    checks++; if (func_e !== ALU_AND) begin failures++; $display("FAIL mid_reset_func got=%b exp=0000", func_e); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd6, 32'd7);
    wait_done(1'b0, 40, lat);
    checks++; if (lat != 10) begin failures++; $display("FAIL after_reset_latency got=%0d exp=10", lat); end
    checks++; if (result_e !== 32'd42) begin failures++; $display("FAIL after_reset_result got=%0d exp=42", result_e); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op_a = 32'd2; op_b = 32'd3; start_e = 1'b1;
    @(negedge clk);
    wait_done(1'b0, 40, lat);
    checks++; if (lat != 7) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=7", lat); end
    checks++; if (result_e !== 32'd6) begin failures++; $display("FAIL b2b_first_result got=%0d exp=6", result_e); end
    op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    checks++; if (busy_e !== 1'b0 || done_e !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got busy=%b done=%b exp=0,0", busy_e, done_e); end
    @(negedge clk);
    start_e = 1'b0;
    checks++; if (busy_e !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", busy_e); end
    wait_done(1'b0, 40, lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=9", lat); end
    checks++; if (result_e !== 32'd25) begin failures++; $display("FAIL b2b_second_result got=%0d exp=25", result_e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_ones();
    test_full_length();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
